// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the CPU/host data RAM arbiter: FSM states and read-return owner tags.
package mem_port_arbiter_pkg;

  typedef enum logic {
    S_CPU  = 1'b0,
    S_HOST = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } rd_owner_t;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; sat flags that the count sits at MAX.
module arb_sat_counter #(
  parameter int CNT_W = 3,
  parameter int MAX   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic sat
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX);

  logic [CNT_W-1:0] cnt_reg;

  assign sat = (cnt_reg == MAX_V);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (inc && !sat) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port synchronous data RAM between the CPU data port and a host port.
// The CPU has priority; a host starved for STARVE_LIMIT cycles stalls the CPU for up to HOST_BURST_MAX grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT   = 4,
  parameter int HOST_BURST_MAX = 2,
  parameter int CNT_W          = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_re,
  input  logic [3:0]  cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        host_req,
  input  logic [3:0]  host_we,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_gnt,
  output logic        host_rvalid,
  output logic [31:0] host_rdata,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_we,
  output logic        ram_re,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  arb_state_t state_reg, state_next;
  rd_owner_t  rd_owner_reg, rd_owner_next;
  logic        hold_valid_reg;
  logic [31:0] hold_data_reg;

  logic cpu_act;
  logic sel_cpu, sel_host;
  logic wait_clr, wait_inc, wait_sat;
  logic burst_clr, burst_inc, burst_sat;
  logic hold_capture;

  assign cpu_act   = cpu_re | (|cpu_we);
  assign cpu_stall = (state_reg == S_HOST);

  // Counters saturate one below their limit: reaching sat is exactly the trigger condition.
  arb_sat_counter #(.CNT_W(CNT_W), .MAX(STARVE_LIMIT - 1)) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .clr (wait_clr),
    .inc (wait_inc),
    .sat (wait_sat)
  );

  arb_sat_counter #(.CNT_W(CNT_W), .MAX(HOST_BURST_MAX - 1)) u_burst_cnt (
    .clk (clk),
    .rst (rst),
    .clr (burst_clr),
    .inc (burst_inc),
    .sat (burst_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_CPU;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_cpu    = 1'b0;
    sel_host   = 1'b0;
    host_gnt   = 1'b0;
    wait_clr   = 1'b0;
    wait_inc   = 1'b0;
    burst_clr  = 1'b0;
    burst_inc  = 1'b0;
    case (state_reg)
      S_CPU: begin
        burst_clr = 1'b1;
        if (cpu_act) begin
          sel_cpu = 1'b1;
        end else if (host_req) begin
          sel_host = 1'b1;
          host_gnt = 1'b1;
        end
        wait_clr = host_gnt | ~host_req;
        wait_inc = host_req & cpu_act;
        if (host_req && cpu_act && wait_sat) begin
          state_next = S_HOST;
        end
      end
      S_HOST: begin
        // Every S_HOST cycle is either a grant or the exit, so the starvation count always restarts.
        wait_clr = 1'b1;
        if (host_req) begin
          sel_host  = 1'b1;
          host_gnt  = 1'b1;
          burst_inc = 1'b1;
          if (burst_sat) begin
            state_next = S_CPU;
          end
        end else begin
          state_next = S_CPU;
        end
      end
      default: state_next = S_CPU;
    endcase
  end

  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_we    = 4'b0000;
    ram_re    = 1'b0;
    if (sel_cpu) begin
      ram_we = cpu_we;
      ram_re = cpu_re;
    end else if (sel_host) begin
      ram_addr  = host_addr;
      ram_wdata = host_wdata;
      ram_we    = host_we;
      ram_re    = ~(|host_we);
    end
  end

  always_comb begin
    rd_owner_next = OWN_NONE;
    if (ram_re) begin
      rd_owner_next = sel_host ? OWN_HOST : OWN_CPU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_owner_reg <= OWN_NONE;
    end else begin
      rd_owner_reg <= rd_owner_next;
    end
  end

  // A CPU read landing while the pipeline is frozen must survive until the CPU runs again.
  assign hold_capture = (rd_owner_reg == OWN_CPU) && cpu_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_reg <= 1'b0;
    end else if (hold_capture) begin
      hold_valid_reg <= 1'b1;
    end else if (!cpu_stall) begin
      hold_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (hold_capture) begin
      hold_data_reg <= ram_rdata;
    end
  end

  assign cpu_rdata   = hold_valid_reg ? hold_data_reg : ram_rdata;
  assign host_rvalid = (rd_owner_reg == OWN_HOST);
  assign host_rdata  = ram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter against a cycle-level behavioural reference model.
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT   = 4;
  localparam int HOST_BURST_MAX = 2;

  logic        clk;
  logic        rst;
  logic        cpu_re;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        host_req;
  logic [3:0]  host_we;
  logic [31:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_gnt;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic [31:0] ram_addr;
  logic [3:0]  ram_we;
  logic        ram_re;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  mem_port_arbiter #(
    .STARVE_LIMIT   (STARVE_LIMIT),
    .HOST_BURST_MAX (HOST_BURST_MAX),
    .CNT_W          (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_re      (cpu_re),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_re      (ram_re),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical RAM attached to the DUT: 128 words, read-before-write, one cycle read latency.
  logic [31:0] ram_mem [128];
  always @(posedge clk) begin
    if (ram_re) ram_rdata <= ram_mem[ram_addr[8:2]];
    for (int b = 0; b < 4; b++) begin
      if (ram_we[b]) ram_mem[ram_addr[8:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  int vectors     = 0;
  int miscompares = 0;
  int checks      = 0;

  // Reference model: transaction-level view of who owns the RAM and what each requester should see.
  logic [31:0] model_mem [128];
  bit          stealing;
  int          denied;
  int          stolen;
  int          ret_who;     // 0 none, 1 cpu, 2 host
  logic [31:0] ret_data;
  bit          held_valid;
  logic [31:0] held_val;
  bit          last_gnt;

  task automatic model_reset();
    stealing   = 1'b0;
    denied     = 0;
    stolen     = 0;
    ret_who    = 0;
    ret_data   = '0;
    held_valid = 1'b0;
    held_val   = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%08h expected=%08h (vector %0d)", tag, obs, exp_v, vectors);
    end
  endtask

  task automatic step(input logic c_re, input logic [3:0] c_we, input logic [31:0] c_addr,
                      input logic [31:0] c_wd, input logic h_rq, input logic [3:0] h_we,
                      input logic [31:0] h_addr, input logic [31:0] h_wd, input logic rs);
    bit          act, cpu_go, host_go, e_re;
    logic [3:0]  e_we;
    logic [31:0] e_addr, e_wd, rd_val;
    cpu_re     = c_re;
    cpu_we     = c_we;
    cpu_addr   = c_addr;
    cpu_wdata  = c_wd;
    host_req   = h_rq;
    host_we    = h_we;
    host_addr  = h_addr;
    host_wdata = h_wd;
    rst        = rs;
    @(negedge clk);
    vectors++;
    act     = c_re || (c_we != 4'b0000);
    cpu_go  = !stealing && act;
    host_go = h_rq && (stealing || !act);
    e_re = 1'b0; e_we = 4'b0000; e_addr = '0; e_wd = '0;
    if (cpu_go) begin
      e_re = c_re; e_we = c_we; e_addr = c_addr; e_wd = c_wd;
    end else if (host_go) begin
      e_re = (h_we == 4'b0000); e_we = h_we; e_addr = h_addr; e_wd = h_wd;
    end
    chk("cpu_stall", 32'(cpu_stall), 32'(stealing));
    chk("host_gnt", 32'(host_gnt), 32'(host_go));
    chk("ram_re", 32'(ram_re), 32'(e_re));
    chk("ram_we", 32'(ram_we), 32'(e_we));
    if (e_re || e_we != 4'b0000) chk("ram_addr", ram_addr, e_addr);
    if (e_we != 4'b0000) chk("ram_wdata", ram_wdata, e_wd);
    chk("host_rvalid", 32'(host_rvalid), 32'(ret_who == 2));
    if (ret_who == 2) chk("host_rdata", host_rdata, ret_data);
    if (ret_who == 1) chk("cpu_rdata", cpu_rdata, ret_data);
    else if (held_valid) chk("cpu_rdata_hold", cpu_rdata, held_val);
    $display("vec %0d rst=%b cpu re=%b we=%h a=%h | host req=%b we=%h a=%h | gnt=%b stall=%b",
             vectors, rs, c_re, c_we, c_addr, h_rq, h_we, h_addr, host_gnt, cpu_stall);
    @(posedge clk);
    rd_val = model_mem[e_addr[8:2]];
    for (int b = 0; b < 4; b++) begin
      if (e_we[b]) model_mem[e_addr[8:2]][8*b +: 8] = e_wd[8*b +: 8];
    end
    last_gnt = host_go;
    if (rs) begin
      model_reset();
    end else begin
      if (ret_who == 1 && stealing) begin
        held_valid = 1'b1;
        held_val   = ret_data;
      end else if (!stealing) begin
        held_valid = 1'b0;
      end
      ret_who  = e_re ? (cpu_go ? 1 : 2) : 0;
      ret_data = rd_val;
      if (!stealing) begin
        if (h_rq && act) begin
          denied++;
          if (denied == STARVE_LIMIT) begin
            stealing = 1'b1;
            stolen   = 0;
            denied   = 0;
          end
        end else begin
          denied = 0;
        end
      end else begin
        denied = 0;
        if (h_rq) begin
          stolen++;
          if (stolen == HOST_BURST_MAX) stealing = 1'b0;
        end else begin
          stealing = 1'b0;
        end
      end
    end
    #1;
  endtask

  logic        r_re, r_hq, r_rs;
  logic [3:0]  r_we, r_hwe;
  logic [31:0] r_addr, r_wd, r_haddr, r_hwd;
  int          op;

  initial begin
    for (int i = 0; i < 128; i++) begin
      ram_mem[i]   = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
      model_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
    end
    ram_mem[64]   = 32'hDEAD_BEEF;  model_mem[64] = 32'hDEAD_BEEF;
    ram_mem[16]   = 32'h1234_5678;  model_mem[16] = 32'h1234_5678;
    ram_rdata = '0;
    model_reset();
    last_gnt = 1'b0;

    rst = 1'b1; cpu_re = 1'b0; cpu_we = '0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = '0; host_addr = '0; host_wdata = '0;
    @(posedge clk);
    @(posedge clk);
    #1;

    // Reset state
    step(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1);
    step(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);

    // Host read in an idle CPU slot, data next cycle
    step(0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h100, 32'h0, 0);
    step(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);

    // CPU reads every cycle with host held: starvation, steal burst, CPU read held across stall
    for (int i = 0; i < 10; i++)
      step(1, 4'h0, 32'h40, 32'h0, 1, 4'h0, 32'h80, 32'h0, 0);
    step(1, 4'h0, 32'h40, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
    step(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);

    // Steal ended early by host_req dropping, then a full new starvation window
    for (int i = 0; i < STARVE_LIMIT + 1; i++)
      step(1, 4'h0, 32'h40, 32'h0, 1, 4'hF, 32'h84, 32'hCAFE_0001, 0);
    step(1, 4'h0, 32'h40, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
    for (int i = 0; i < STARVE_LIMIT + 1; i++)
      step(1, 4'h0, 32'h44, 32'h0, 1, 4'h0, 32'h84, 32'h0, 0);
    step(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
    step(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);

    // Reset while stealing with a host read granted in that cycle
    for (int i = 0; i < STARVE_LIMIT; i++)
      step(1, 4'h0, 32'h40, 32'h0, 1, 4'h0, 32'h100, 32'h0, 0);
    step(0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h100, 32'h0, 1);
    step(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);

    // CPU byte write collides with a host write request
    step(0, 4'b0100, 32'h48, 32'h00AB_0000, 1, 4'hF, 32'h88, 32'h5555_AAAA, 0);
    step(0, 4'b0100, 32'h48, 32'h00CD_0000, 1, 4'hF, 32'h88, 32'h5555_AAAA, 0);
    step(0, 4'h0, 32'h0, 32'h0, 1, 4'hF, 32'h88, 32'h5555_AAAA, 0);
    step(1, 4'h0, 32'h48, 32'h0, 1, 4'h0, 32'h88, 32'h0, 0);
    step(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);

    // Randomized traffic; host requests are held until granted
    r_hq = 1'b0; r_hwe = '0; r_haddr = '0; r_hwd = '0;
    for (int n = 0; n < 600; n++) begin
      op = int'($urandom_range(0, 3));
      r_re = (op == 1 || op == 2);
      r_we = (op == 3) ? 4'($urandom_range(1, 15)) : 4'h0;
      r_addr = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
      r_wd = $urandom;
      if (!r_hq && $urandom_range(0, 2) != 0) begin
        r_hq = 1'b1;
        r_hwe = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        r_haddr = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
        r_hwd = $urandom;
      end
      r_rs = ($urandom_range(0, 99) == 0);
      step(r_re, r_we, r_addr, r_wd, r_hq, r_hwe, r_haddr, r_hwd, r_rs);
      if (last_gnt || r_rs) r_hq = 1'b0;
    end
    step(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
